// File: rtl/simple_to_axifull_wr_pkg.sv
// Shared widths, AXI encodings and FSM state type for the simple-to-AXI write bridge.
package simple_to_axifull_wr_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int ADDR_WIDTH     = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int ID_WIDTH       = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_AW      = 2'd1,
        ST_W       = 2'd2,
        ST_B       = 2'd3
    } wr_state_e;

endpackage

// File: rtl/simple_to_axifull_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the bridge and an interconnect slave port.
// Handshake: a transfer happens on a rising clock edge where VALID and READY are both high;
// once VALID is raised the sender holds VALID and payload stable until that edge, and
// READY may be driven freely by the receiver without waiting for VALID.
interface simple_to_axifull_wr_if
    import simple_to_axifull_wr_pkg::*;
#(
    parameter int DW   = AXI_DATA_WIDTH,
    parameter int AW_W = ADDR_WIDTH,
    parameter int IDW  = AXI_ID_WIDTH
);
    logic [IDW-1:0]    AXI_AWID;
    logic [AW_W-1:0]   AXI_AWADDR;
    logic [7:0]        AXI_AWLEN;
    logic [2:0]        AXI_AWSIZE;
    logic [1:0]        AXI_AWBURST;
    logic              AXI_AWLOCK;
    logic [3:0]        AXI_AWCACHE;
    logic [2:0]        AXI_AWPROT;
    logic [3:0]        AXI_AWQOS;
    logic              AXI_AWVALID;
    logic              AXI_AWREADY;

    logic [DW-1:0]     AXI_WDATA;
    logic [DW/8-1:0]   AXI_WSTRB;
    logic              AXI_WLAST;
    logic              AXI_WVALID;
    logic              AXI_WREADY;

    logic [IDW-1:0]    AXI_BID;
    logic [1:0]        AXI_BRESP;
    logic              AXI_BVALID;
    logic              AXI_BREADY;

    modport master (
        output AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWLOCK,
        output AXI_AWCACHE, AXI_AWPROT, AXI_AWQOS, AXI_AWVALID,
        input  AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
        input  AXI_WREADY,
        input  AXI_BID, AXI_BRESP, AXI_BVALID,
        output AXI_BREADY
    );

    modport slave (
        input  AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWLOCK,
        input  AXI_AWCACHE, AXI_AWPROT, AXI_AWQOS, AXI_AWVALID,
        output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
        output AXI_WREADY,
        output AXI_BID, AXI_BRESP, AXI_BVALID,
        input  AXI_BREADY
    );

endinterface

// File: rtl/simple_to_axifull_wr_fifo.sv
// First-word-fall-through synchronous FIFO: dout_o always shows the oldest entry.
// Push on full and pop on empty are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy tracking; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/simple_to_axifull_wr.sv
// Collects simple-port packets into a buffer and replays each as one AXI4 INCR write burst.
// Packets longer than MAX_BURST are split into consecutive bursts sharing the same AWID.
module simple_to_axifull_wr
    import simple_to_axifull_wr_pkg::*;
#(
    parameter int              MAX_BURST = 256,
    parameter int              DW        = AXI_DATA_WIDTH,
    parameter int              AW_W      = ADDR_WIDTH,
    parameter int              IDW       = AXI_ID_WIDTH,
    parameter logic [AW_W-1:0] BASE_ADDR = '0,
    parameter int              CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] master_id,
    input  logic [DW-1:0]       master_data,
    input  logic                master_valid,
    input  logic                master_begin_flag,
    input  logic                master_last_flag,
    output logic                master_ready,
    simple_to_axifull_wr_if.master axi,
    output logic                wr_err,
    output wr_state_e           dbg_state_o,
    output logic [CNT_W-1:0]    dbg_fifo_count_o
);

    localparam int BYTE_SHIFT = $clog2(DW / 8);

    wr_state_e        state_q, state_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0]   awid_q, awid_d;
    logic [AW_W-1:0]  awaddr_q, awaddr_d;
    logic [7:0]       awlen_q, awlen_d;
    logic [7:0]       w_cnt_q, w_cnt_d;
    logic             wr_err_q, wr_err_d;
    // Set when a burst closed on MAX_BURST without last: the next beat continues the packet.
    logic             cont_q, cont_d;

    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [DW-1:0]    fifo_dout;
    logic             wvalid, wlast;
    logic [AW_W-1:0]  burst_bytes;

    sync_fifo_fwft #(
        .WIDTH (DW),
        .DEPTH (MAX_BURST),
        .CW    (CNT_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (master_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (dbg_fifo_count_o)
    );

    assign wvalid      = (state_q == ST_W) && !fifo_empty;
    assign wlast       = wvalid && (w_cnt_q == awlen_q);
    assign burst_bytes = AW_W'({1'b0, awlen_q} + 9'd1) << BYTE_SHIFT;

    assign master_ready = ready_q;
    assign wr_err       = wr_err_q;
    assign dbg_state_o  = state_q;

    assign axi.AXI_AWID    = awid_q;
    assign axi.AXI_AWADDR  = awaddr_q;
    assign axi.AXI_AWLEN   = awlen_q;
    assign axi.AXI_AWSIZE  = 3'(BYTE_SHIFT);
    assign axi.AXI_AWBURST = AXI_BURST_INCR;
    assign axi.AXI_AWLOCK  = 1'b0;
    assign axi.AXI_AWCACHE = AXI_CACHE_DEF;
    assign axi.AXI_AWPROT  = 3'b000;
    assign axi.AXI_AWQOS   = 4'b0000;
    assign axi.AXI_AWVALID = (state_q == ST_AW);
    assign axi.AXI_WDATA   = fifo_dout;
    assign axi.AXI_WSTRB   = '1;
    assign axi.AXI_WLAST   = wlast;
    assign axi.AXI_WVALID  = wvalid;
    assign axi.AXI_BREADY  = (state_q == ST_B);

    // Next-state, counters and burst fields for the COLLECT -> AW -> W -> B cycle.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        awid_d     = awid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        w_cnt_d    = w_cnt_q;
        wr_err_d   = wr_err_q;
        cont_d     = cont_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (master_valid && ready_q && !fifo_full) begin
                    fifo_push  = 1'b1;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if ((beat_cnt_q == '0) && (master_begin_flag || !cont_q)) begin
                        awid_d = IDW'(master_id);
                    end
                    if (master_last_flag || (beat_cnt_d == CNT_W'(MAX_BURST))) begin
                        awlen_d = 8'(beat_cnt_q);
                        cont_d  = !master_last_flag;
                        state_d = ST_AW;
                    end
                end
            end
            ST_AW: begin
                if (axi.AXI_AWREADY) begin
                    w_cnt_d = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (wvalid && axi.AXI_WREADY) begin
                    fifo_pop = 1'b1;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (wlast) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (axi.AXI_BVALID) begin
                    wr_err_d   = wr_err_q | (axi.AXI_BRESP != AXI_RESP_OKAY);
                    awaddr_d   = awaddr_q + burst_bytes;
                    beat_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
        endcase
        ready_d = (state_d == ST_COLLECT);
    end

    // State and burst registers; reset drops any in-flight burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            ready_q    <= 1'b0;
            beat_cnt_q <= '0;
            awid_q     <= '0;
            awaddr_q   <= BASE_ADDR;
            awlen_q    <= '0;
            w_cnt_q    <= '0;
            wr_err_q   <= 1'b0;
            cont_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            beat_cnt_q <= beat_cnt_d;
            awid_q     <= awid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            w_cnt_q    <= w_cnt_d;
            wr_err_q   <= wr_err_d;
            cont_q     <= cont_d;
        end
    end

endmodule

// File: tb/tb_simple_to_axifull_wr.sv
// Bench for simple_to_axifull_wr: random packets against a burst-level reference model.
module tb_simple_to_axifull_wr;
    import simple_to_axifull_wr_pkg::*;

    localparam int              DW        = 32;
    localparam int              AW_W      = 32;
    localparam int              IDW       = 4;
    localparam int              MAX_BURST = 256;
    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [AW_W-1:0] BASE      = 32'h0000_1000;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [AW_W-1:0] addr;
        logic [7:0]      len;
    } aw_rec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ID_WIDTH-1:0] master_id;
    logic [DW-1:0]       master_data;
    logic                master_valid, master_begin_flag, master_last_flag, master_ready;
    logic                wr_err;
    wr_state_e           dbg_state;
    logic [CNT_W-1:0]    dbg_fifo_count;

    simple_to_axifull_wr_if #(.DW(DW), .AW_W(AW_W), .IDW(IDW)) axi ();

    simple_to_axifull_wr #(
        .MAX_BURST (MAX_BURST),
        .DW        (DW),
        .AW_W      (AW_W),
        .IDW       (IDW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .master_id         (master_id),
        .master_data       (master_data),
        .master_valid      (master_valid),
        .master_begin_flag (master_begin_flag),
        .master_last_flag  (master_last_flag),
        .master_ready      (master_ready),
        .axi               (axi),
        .wr_err            (wr_err),
        .dbg_state_o       (dbg_state),
        .dbg_fifo_count_o  (dbg_fifo_count)
    );

    // ---------------- scoreboard / model state ----------------
    logic [DW-1:0]   exp_q[$];
    aw_rec_t         exp_aw_q[$];
    logic [1:0]      bresp_q[$];
    logic [AW_W-1:0] exp_addr;
    logic            exp_err;
    bit              stall_en;
    int              n_checks, n_fail;
    int              w_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_aw_q.delete();
        bresp_q.delete();
        exp_addr = BASE;
        exp_err  = 1'b0;
    endtask

    // ---------------- AW / W ready driver ----------------
    initial begin
        axi.AXI_AWREADY = 1'b1;
        axi.AXI_WREADY  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axi.AXI_AWREADY = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.AXI_WREADY  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- B responder ----------------
    initial begin
        axi.AXI_BVALID = 1'b0;
        axi.AXI_BRESP  = 2'b00;
        axi.AXI_BID    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.AXI_BVALID = 1'b0;
            end else if (axi.AXI_BVALID && axi.AXI_BREADY) begin
                @(posedge clk);
                #1;
                if (axi.AXI_BRESP != 2'b00) exp_err = 1'b1;
                axi.AXI_BVALID = 1'b0;
            end else if (axi.AXI_BREADY && !axi.AXI_BVALID && (!stall_en || $urandom_range(0, 1) == 1)) begin
                @(posedge clk);
                #1;
                axi.AXI_BVALID = 1'b1;
                axi.AXI_BRESP  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            end
        end
    end

    // ---------------- monitor: AXI side against the model ----------------
    initial begin
        bit         aw_stall, w_stall;
        aw_rec_t    aw_prev, aw_cur, r;
        logic [DW:0] w_prev;
        logic [7:0] cur_len;
        int         w_idx;
        aw_stall = 0; w_stall = 0; cur_len = '0; w_idx = 0; w_prev = '0; aw_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_stall = 0;
                w_stall  = 0;
            end else begin
                if (axi.AXI_AWVALID || axi.AXI_WVALID || axi.AXI_BREADY)
                    check_eq("ready_busy", master_ready, 0);
                aw_cur = '{id: axi.AXI_AWID, addr: axi.AXI_AWADDR, len: axi.AXI_AWLEN};
                if (aw_stall) check_eq("aw_hold", {axi.AXI_AWVALID, aw_cur}, {1'b1, aw_prev});
                if (axi.AXI_AWVALID) begin
                    if (axi.AXI_AWREADY) begin
                        aw_stall = 0;
                        check_eq("aw_expected", exp_aw_q.size() != 0, 1);
                        if (exp_aw_q.size() != 0) begin
                            r = exp_aw_q.pop_front();
                            check_eq("awid", aw_cur.id, r.id);
                            check_eq("awaddr", aw_cur.addr, r.addr);
                            check_eq("awlen", aw_cur.len, r.len);
                            cur_len = r.len;
                        end
                        w_idx = 0;
                        check_eq("aw_const",
                                 {axi.AXI_AWSIZE, axi.AXI_AWBURST, axi.AXI_AWLOCK, axi.AXI_AWCACHE,
                                  axi.AXI_AWPROT, axi.AXI_AWQOS},
                                 {3'd2, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0});
                    end else begin
                        aw_stall = 1;
                        aw_prev  = aw_cur;
                    end
                end else begin
                    aw_stall = 0;
                end
                if (w_stall) check_eq("w_hold", {axi.AXI_WVALID, axi.AXI_WLAST, axi.AXI_WDATA}, {1'b1, w_prev});
                if (axi.AXI_WVALID) begin
                    if (axi.AXI_WREADY) begin
                        w_stall = 0;
                        check_eq("w_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) check_eq("wdata", axi.AXI_WDATA, exp_q.pop_front());
                        check_eq("wlast", axi.AXI_WLAST, (w_idx == int'(cur_len)));
                        check_eq("wstrb", axi.AXI_WSTRB, 4'hf);
                        w_idx++;
                        w_seen++;
                    end else begin
                        w_stall = 1;
                        w_prev  = {axi.AXI_WLAST, axi.AXI_WDATA};
                    end
                end else begin
                    w_stall = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input logic [IDW-1:0] id, input int n, input bit pattern);
        logic [DW-1:0] d[$];
        aw_rec_t       rec;
        int            remain, len, wait_cnt;
        bit            hs;
        for (int i = 0; i < n; i++) d.push_back(pattern ? DW'(32'h11 * (i + 1)) : DW'($urandom));
        // Reference model: chop the packet into MAX_BURST chunks at consecutive addresses.
        remain = n;
        while (remain > 0) begin
            len       = (remain > MAX_BURST) ? MAX_BURST : remain;
            rec.id    = id;
            rec.addr  = exp_addr;
            rec.len   = 8'(len - 1);
            exp_aw_q.push_back(rec);
            exp_addr  = exp_addr + AW_W'(len * (DW / 8));
            remain   -= len;
        end
        foreach (d[i]) exp_q.push_back(d[i]);
        for (int i = 0; i < n; i++) begin
            if (stall_en) begin
                master_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            master_valid      = 1'b1;
            master_id         = ID_WIDTH'(id);
            master_data       = d[i];
            master_begin_flag = (i == 0);
            master_last_flag  = (i == n - 1);
            hs = 0;
            wait_cnt = 0;
            while (!hs && wait_cnt < 3000) begin
                @(negedge clk);
                hs = master_ready;
                @(posedge clk);
                wait_cnt++;
            end
            #1;
            check_eq("beat_accept", hs, 1);
            if (!hs) break;
            if ((i == n - 1) || ((i + 1) % MAX_BURST == 0)) begin
                master_valid = 1'b0;
                @(negedge clk);
                check_eq("aw_latency", axi.AXI_AWVALID, 1);
                check_eq("ready_drop", master_ready, 0);
                @(posedge clk);
                #1;
            end
        end
        master_valid      = 1'b0;
        master_begin_flag = 1'b0;
        master_last_flag  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 8000 && !done; i++) begin
            @(posedge clk);
            done = (exp_aw_q.size() == 0) && (exp_q.size() == 0) &&
                   (dbg_state == ST_COLLECT) && !axi.AXI_BVALID;
        end
        #1;
        check_eq("idle_reached", done, 1);
        check_eq("fifo_drained", dbg_fifo_count, 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valids"},
                 {master_ready, axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_WLAST, axi.AXI_BREADY}, 5'b0);
        check_eq({tag, "_awaddr"}, axi.AXI_AWADDR, BASE);
        check_eq({tag, "_wr_err"}, wr_err, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        bit reached;
        n_checks = 0; n_fail = 0; w_seen = 0; stall_en = 0;
        master_valid = 0; master_begin_flag = 0; master_last_flag = 0;
        master_id = '0; master_data = '0;
        model_clear();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_awlen_awid", {axi.AXI_AWLEN, axi.AXI_AWID}, 12'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-beat pattern packet, then a single begin+last beat
        send_pkt(4'd3, 4, 1'b1);
        wait_idle();
        check_eq("next_addr", axi.AXI_AWADDR, BASE + 32'd16);
        send_pkt(4'd7, 1, 1'b1);
        wait_idle();

        // packet longer than MAX_BURST is split into two bursts with the same id
        send_pkt(4'd5, 300, 1'b0);
        wait_idle();
        check_eq("wr_err_ok", wr_err, exp_err);

        // random lengths and ids with ready/valid stalls on every channel
        stall_en = 1;
        for (int p = 0; p < 10; p++) send_pkt(IDW'($urandom), $urandom_range(1, 40), 1'b0);
        wait_idle();

        // second burst of three answers SLVERR; the flag must stick through later OKAYs
        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b10);
        for (int p = 0; p < 3; p++) send_pkt(IDW'(p + 8), $urandom_range(1, 8), 1'b0);
        wait_idle();
        check_eq("wr_err_set", wr_err, exp_err);
        send_pkt(4'd1, 5, 1'b0);
        wait_idle();
        check_eq("wr_err_sticky", wr_err, exp_err);

        // reset in the middle of the W phase
        stall_en = 0;
        w0 = w_seen;
        send_pkt(4'd2, 4, 1'b0);
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk);
            reached = (w_seen >= w0 + 2);
        end
        check_eq("mid_w_reached", reached, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(4'd4, 3, 1'b0);
        wait_idle();
        check_eq("post_reset_addr", axi.AXI_AWADDR, BASE + 32'd12);

        check_eq("exp_q_drained", exp_q.size(), 0);
        check_eq("exp_aw_drained", exp_aw_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_to_axifull_wr.md
Name: simple_to_axifull_wr

Overview:
- Master-side counterpart of the AXI-full write slave. Collects packets from the simple interface (id/data/valid/begin/last) into an internal buffer.
- Replays each packet as one AXI4 INCR write burst (AW, then W, then B), with AWLEN set from the buffered beat count.
- Sits between a simple-port producer and an AXI interconnect slave port.

Parameters:
- MAX_BURST, 256, maximum beats per burst; a packet longer than this is split.
- BASE_ADDR, 0, byte address of the first burst after reset.
- DW, `AXI_DATA_WIDTH, data width.
- AW_W, `ADDR_WIDTH, address width.
- IDW, `AXI_ID_WIDTH, AXI ID width; simple id is `ID_WIDTH, zero-extended or truncated to IDW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- master_id  in  `ID_WIDTH  packet id; sampled on the begin beat.
- master_data  in  DW  beat data.
- master_valid  in  1  beat valid.
- master_begin_flag  in  1  first beat of packet.
- master_last_flag  in  1  last beat of packet.
- master_ready  out  1  beat accepted when valid&&ready.
- AXI_AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWLOCK/AWCACHE[3:0]/AWPROT[2:0]/AWQOS[3:0]  out  AW fields.
- AXI_AWVALID out 1; AXI_AWREADY in 1.
- AXI_WDATA out DW; AXI_WSTRB out DW/8; AXI_WLAST out 1; AXI_WVALID out 1; AXI_WREADY in 1.
- AXI_BID in IDW; AXI_BRESP in 2; AXI_BVALID in 1; AXI_BREADY out 1.
- wr_err  out  1  sticky; set on any BRESP!=2'b00 and cleared only by reset.

Behaviour:
- Constant outputs: AWSIZE=$clog2(DW/8), AWBURST=2'b01, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, WSTRB all ones.
- Reset: state=COLLECT. All VALID/READY outputs, WLAST, AWLEN, AWID and wr_err are 0. AWADDR=BASE_ADDR. Buffer is flushed.
- A reset mid-burst drops the burst; no B is awaited.
- State machine COLLECT -> AW -> W -> B -> COLLECT.
- COLLECT:
  - master_ready=1.
  - Each accepted beat is pushed into the buffer and increments beat_cnt.
  - An accepted beat with begin_flag, or the first accepted beat when beat_cnt==0, latches the id.
  - begin_flag when beat_cnt>0 is ignored; the data is still stored.
  - Burst closes on an accepted beat with last_flag, or on the accepted beat that makes beat_cnt==MAX_BURST.
  - On close: AWLEN<=beat_cnt_final-1, go to AW. master_ready=0 from the next cycle.
  - A beat carrying both begin and last gives a 1-beat burst with AWLEN=0.
- Split packet: the next burst continues with the same latched id. The next beat needs no begin flag.
- AW:
  - AWVALID=1 the cycle after close, held stable until AWREADY.
  - On the handshake: AWVALID=0, go to W.
- W:
  - WVALID=1 while the buffer is non-empty. WDATA = buffer head (first-word-fall-through).
  - Each WVALID&&WREADY pops one beat and increments w_cnt.
  - WLAST=1 when w_cnt==AWLEN.
  - On the WLAST handshake: WVALID=0, go to B.
  - WREADY low holds WDATA/WLAST stable.
- B:
  - BREADY=1.
  - On BVALID: set wr_err if BRESP!=0; AWADDR += (AWLEN+1)*(DW/8), wrapping modulo 2^AW_W; beat_cnt=0; go to COLLECT.
  - BID is not checked.
- Latency: last beat accepted in cycle N -> AWVALID in N+1; first WVALID in the cycle after the AW handshake.
- Buffer depth = MAX_BURST. It cannot overflow because ready drops at close.

Decomposition:
- Shared package pkg.vh: AXI_ID_WIDTH, ADDR_WIDTH, AXI_DATA_WIDTH, ID_WIDTH, plus new constants AXI_BURST_INCR=2'b01, AXI_CACHE_DEF=4'b0010, AXI_RESP_OKAY=2'b00.
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH; push/pop/empty/full/count, async active-low reset) holds the beat buffer.
- FSM, counters and AXI register outputs stay in the top module.

Test Plan:
- 4-beat packet, id=3, data 0x11..0x44, AWREADY/WREADY tied 1 -> AWLEN=3, AWADDR=BASE_ADDR, AWID=3, WLAST on beat 0x44, BREADY=1. Next AWADDR = BASE_ADDR + 4*DW/8.
- Single beat with begin+last -> AWLEN=0; WLAST on the first W beat.
- 300-beat packet, MAX_BURST=256 -> burst 1 AWLEN=255, burst 2 AWLEN=43, same AWID; addresses contiguous.
- Random AWREADY/WREADY stalls (50%) -> AW fields, WDATA and WLAST stable while stalled; data order preserved; master_ready=0 from the close until B.
- BRESP=2'b10 on the second burst -> wr_err=1 and stays 1 through later OKAY bursts until rst_n low.
- rst_n pulled low during W after 2 of 4 beats -> all VALIDs 0 at once, AWADDR=BASE_ADDR. A new packet after release starts with AWLEN from the new beat count.
